// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the two-client memory request arbiter.
// Client ids double as the tags stored in the read-owner FIFO.
package mem_req_arbiter_pkg;

  localparam int CPU_ADDR_BITS = 32;
  localparam int BE_W          = 4;

  typedef enum logic {
    CLIENT_IFETCH = 1'b0,
    CLIENT_DATA   = 1'b1
  } client_e;

endpackage

// File: rtl/mem_tag_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy count.
// Head is read combinationally; push and pop may occur together.
module mem_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // tag storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of fetch and data requests onto one memory port.
// Read owners are tracked in order so responses route back with no delay.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int CPU_WIDTH       = 32,
  parameter int WORD_ADDR_BITS  = CPU_ADDR_BITS - $clog2(BE_W),
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      c0_req_val,
  output logic                      c0_req_rdy,
  input  logic [WORD_ADDR_BITS-1:0] c0_req_addr,
  input  logic [CPU_WIDTH-1:0]      c0_req_data,
  input  logic [BE_W-1:0]           c0_req_write,
  output logic                      c0_resp_val,
  output logic [CPU_WIDTH-1:0]      c0_resp_data,
  input  logic                      c1_req_val,
  output logic                      c1_req_rdy,
  input  logic [WORD_ADDR_BITS-1:0] c1_req_addr,
  input  logic [CPU_WIDTH-1:0]      c1_req_data,
  input  logic [BE_W-1:0]           c1_req_write,
  output logic                      c1_resp_val,
  output logic [CPU_WIDTH-1:0]      c1_resp_data,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_data,
  output logic [BE_W-1:0]           mem_req_write,
  input  logic                      mem_resp_val,
  input  logic [CPU_WIDTH-1:0]      mem_resp_data,
  output logic                      err_orphan_resp
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  client_e       last_grant;
  client_e       gnt_id;
  logic          gnt1;
  logic          can_issue;
  logic          fire;
  logic          push;
  logic          pop;
  logic [0:0]    tag_head;
  logic          tag_empty;
  logic          tag_full;
  logic [CW-1:0] tag_cnt;

  mem_tag_fifo #(
    .W     (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (1'(gnt_id)),
    .head  (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .count (tag_cnt)
  );

  // grant and request routing
  always_comb begin
    gnt1      = c1_req_val &&
                (!c0_req_val || last_grant == CLIENT_IFETCH);
    gnt_id    = gnt1 ? CLIENT_DATA : CLIENT_IFETCH;
    pop       = mem_resp_val && !tag_empty;
    can_issue = !tag_full || pop;

    mem_req_val   = reset && (c0_req_val || c1_req_val) && can_issue;
    mem_req_addr  = gnt1 ? c1_req_addr  : c0_req_addr;
    mem_req_data  = gnt1 ? c1_req_data  : c0_req_data;
    mem_req_write = gnt1 ? c1_req_write : c0_req_write;

    fire       = mem_req_val && mem_req_rdy;
    push       = fire && (mem_req_write == '0);
    c0_req_rdy = fire && !gnt1;
    c1_req_rdy = fire && gnt1;
  end

  // response routing by head tag
  always_comb begin
    c0_resp_val  = reset && pop && (tag_head == CLIENT_IFETCH);
    c1_resp_val  = reset && pop && (tag_head == CLIENT_DATA);
    c0_resp_data = mem_resp_data;
    c1_resp_data = mem_resp_data;
  end

  // round-robin pointer moves only on an accepted request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    last_grant <= CLIENT_DATA;
    else if (fire) last_grant <= gnt_id;
  end

  // sticky flag for a response with nothing outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_orphan_resp <= 1'b0;
    else if (mem_resp_val && tag_cnt == '0) err_orphan_resp <= 1'b1;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Two-client request arbiter directly upstream of the single-port word memory model.
- Merges the instruction-fetch (client 0) and data (client 1) request streams onto one memory request port.
- Tracks the owner of every outstanding read in an in-order tag FIFO and routes each memory response back to that client.
- Lets a fetch and a load share one memory without per-client memory instances.

Parameters:
- CPU_WIDTH, 32, data word width in bits.
- WORD_ADDR_BITS, 30, word address width (CPU_ADDR_BITS minus log2 of bytes per word).
- MAX_OUTSTANDING, 2, read-tag FIFO depth; power of two, at least 1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset); assertion is asynchronous, release is synchronous to clk.
- c0_req_val  input  1  client 0 request valid.
- c0_req_rdy  output  1  client 0 request accepted this cycle.
- c0_req_addr  input  WORD_ADDR_BITS  client 0 word address.
- c0_req_data  input  CPU_WIDTH  client 0 write data.
- c0_req_write  input  4  client 0 byte write enables; 0 means read.
- c0_resp_val  output  1  client 0 read response valid.
- c0_resp_data  output  CPU_WIDTH  client 0 read data.
- c1_* (7 ports)  same directions and widths as c0_*  client 1 (data port).
- mem_req_val  output  1  request to memory.
- mem_req_rdy  input  1  memory accepts the request.
- mem_req_addr  output  WORD_ADDR_BITS  forwarded address.
- mem_req_data  output  CPU_WIDTH  forwarded write data.
- mem_req_write  output  4  forwarded byte enables.
- mem_resp_val  input  1  memory read response valid.
- mem_resp_data  input  CPU_WIDTH  memory read data.
- err_orphan_resp  output  1  sticky: a response arrived with no outstanding read.

Behaviour:
- Reset values: last_grant=1 (so client 0 wins first), tag FIFO empty, count=0, err_orphan_resp=0.
- While reset is low, all ready and valid outputs are 0.
- Handshake is valid/ready. A transfer happens when val && rdy at a rising edge. A client holds its val and payload stable until it sees rdy.
- can_issue = (count < MAX_OUTSTANDING) || pop_this_cycle. The FIFO full boundary allows a simultaneous push and pop.
- Arbitration is combinational round-robin:
  - If only one client is valid, it gets the grant.
  - If both are valid, the client other than last_grant gets the grant.
  - last_grant updates only on a completed memory transfer.
- mem_req_val = (c0_req_val || c1_req_val) && can_issue.
- mem_req_* is muxed from the granted client.
- cX_req_rdy = granted(X) && can_issue && mem_req_rdy. At most one client is ready per cycle.
- The arbiter adds no request latency: combinational pass-through, no request register.
- A read transfer (write==0) pushes the granted client id (1 bit) into the tag FIFO. A write pushes nothing, because memory gives no write response.
- A response (mem_resp_val=1):
  - If the FIFO is non-empty, pop the head tag.
  - cX_resp_val = mem_resp_val && !empty && head==X.
  - cX_resp_data = mem_resp_data to both clients (unqualified).
  - Responses are in order, with zero added latency. Clients always accept responses; there is no response backpressure.
- Orphan response (mem_resp_val with the FIFO empty): no pop, no client response, err_orphan_resp sets and holds until reset.
- Push and pop in the same cycle: count unchanged, pointers both advance, pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-operation: the FIFO is flushed and in-flight tags are lost. The memory side is reset on the same edge, so no late response is expected; if one arrives, it is an orphan.
- No combinational path from mem_resp_* to mem_req_*, except through can_issue via pop_this_cycle; this is permitted.

Decomposition:
- Shared package/header holds:
  - client-id encoding (CLIENT_IFETCH=0, CLIENT_DATA=1);
  - the byte-enable width constant (4).
  - Existing global CPU_INST_BITS and CPU_ADDR_BITS macros are reused.
- One sub-module, mem_tag_fifo: a synchronous FIFO, parameterised width and depth, with push, pop, head, empty, full and count. The arbiter top holds the round-robin and routing logic.

Test Plan:
- Single read, client 0, addr 0x10, memory ready, response 0xDEADBEEF next cycle -> c0_req_rdy=1 that cycle; c0_resp_val=1 with 0xDEADBEEF one cycle later; c1_resp_val stays 0.
- Both clients request reads continuously, memory always ready -> grants alternate c0,c1,c0,c1; responses route in the same order, with 0xA/0xB payloads matching.
- Client 1 write (write=4'b1111, data 0x12345678) followed by a client 0 read of the same address -> write pushes no tag; the read returns 0x12345678 to client 0 only.
- MAX_OUTSTANDING=2, memory withholds responses -> third read sees cX_req_rdy=0. In the cycle a response arrives the third read is accepted (push and pop together) and count stays 2.
- mem_req_rdy=0 for 3 cycles with c0 valid -> c0_req_rdy=0, no FIFO push, payload stable; accepted on the first rdy cycle.
- Reset pulled low with 2 reads outstanding -> FIFO empty, outputs 0. A later stray mem_resp_val sets err_orphan_resp=1 with no cX_resp_val.
